uart_recv_control: RTL and testbench
====================================

Name: uart_recv_control

Overview:
Receive-side counterpart of the scope's UART transmit path. It deserialises bytes from the host on the RXD line and parses fixed-length command frames: HEAD, CMD, P0..P3, CHK. On a good checksum it presents the command and a 32-bit payload to the acquisition/trigger control logic. It sits between the board RXD pin (asynchronous) and the settings registers in the in_clk domain.

Parameters:
CLK_FREQ, 200000000, system clock frequency in Hz
UART_BPS, 115200, baud rate; BPS_CNT = CLK_FREQ/UART_BPS (integer division)
FRAME_HEAD, 8'hA5, frame start byte
TIMEOUT_BITS, 20, allowed idle time between bytes of one frame, in bit periods

Ports:
in_clk  input  1  system clock
in_rst  input  1  asynchronous active-low reset
in_uart_rxd  input  1  serial receive line, asynchronous, idles high
out_byte_data  output  8  last received byte
out_byte_valid  output  1  1-cycle pulse, out_byte_data updated
out_cmd  output  8  command byte of the last good frame
out_payload  output  32  payload of the last good frame, P0 = bits [31:24]
out_frame_valid  output  1  1-cycle pulse, good frame latched
out_frame_err  output  1  1-cycle pulse: checksum, framing or timeout error
out_uart_recv_busy  output  1  high while a frame is being parsed (not in P_HEAD)

Behaviour:
- Reset (in_rst=0, async): all outputs 0. Bit FSM goes to R_IDLE, parser to P_HEAD, all counters and shift registers cleared. A reset in the middle of a byte or frame discards it, with no pulses.
- RXD passes through a 2-flop synchroniser, then a third flop for edge detection. A falling edge in R_IDLE starts a byte.
- Bit FSM: R_IDLE -> R_START -> R_DATA -> R_STOP -> R_IDLE. The bit counter counts 0..BPS_CNT-1, and each bit is sampled at count BPS_CNT/2.
  - R_START: if the mid-bit sample is 1 (glitch), return to R_IDLE with no pulse.
  - R_DATA: 8 bits, LSB first, shifted in.
  - R_STOP: at the mid-bit sample, stop=1 gives out_byte_data<=byte and out_byte_valid=1 for one cycle. stop=0 is a framing error: no byte pulse, and the error goes to the parser.
  - After the mid-stop sample, return to R_IDLE immediately. A new falling edge is accepted on the next cycle, which tolerates up to half a bit of baud skew.
- Parser FSM (advances on out_byte_valid):
  - P_HEAD: byte==FRAME_HEAD moves to P_CMD. Any other byte is ignored, with no error.
  - P_CMD: latch cmd, sum<=byte, move to P_PAY.
  - P_PAY: 4 bytes, shifted MSB first, sum<=sum+byte (8-bit, wraps mod 256), move to P_CHK.
  - P_CHK: if byte==sum, out_cmd and out_payload update and out_frame_valid pulses in the same cycle. Otherwise out_frame_err pulses and outputs hold. Either way, return to P_HEAD.
- Timeout: outside P_HEAD, a counter counts cycles with no byte. At TIMEOUT_BITS*BPS_CNT it pulses out_frame_err and returns to P_HEAD. The counter clears on every out_byte_valid.
- A framing error outside P_HEAD pulses out_frame_err and returns to P_HEAD. In P_HEAD it is silent.
- Error and valid pulses never coincide. out_cmd and out_payload change only with out_frame_valid.
- Latency: out_byte_valid rises about 9.5 bit periods + 3 cycles after the start edge. out_frame_valid rises 1 cycle after the CHK out_byte_valid.

Optional Feature:
UART_RX_PARITY_EN:
- Defined: an R_PARITY state sits between R_DATA and R_STOP and checks even parity over the data bits plus the parity bit. A mismatch is treated exactly as a framing error.
- Undefined: 8N1, no parity state, and the parity logic is not generated.

Test Plan:
All cases use CLK_FREQ=1600000 and UART_BPS=100000 (16 cycles per bit).
1. Send A5 01 00 00 01 90 92 -> 7 byte pulses, then out_frame_valid=1 for 1 cycle; out_cmd=01, out_payload=32'h00000190, out_frame_err never set.
2. Same frame with CHK=93 -> out_frame_err for 1 cycle; out_cmd and out_payload keep their previous values; out_uart_recv_busy=0 afterwards.
3. Send 3C 00 then a good frame (A5 02 12 34 56 78 16) -> junk ignored with no error; out_payload=32'h12345678, out_cmd=02.
4. Send A5 05, then idle for 330 cycles -> out_frame_err at 320 cycles after the last byte; a following good frame is accepted.
5. Send a 4-cycle low glitch on RXD, then a byte 55 with stop bit forced 0 after A5 -> no byte pulse for the glitch; out_frame_err on the bad stop bit.
6. Assert in_rst mid-payload, release, then send a good frame -> no pulses during the reset; the new frame is decoded correctly.

Source files
------------

// File: rtl/uart_recv_control.sv
// uart_recv_control: 8N1 UART receiver feeding a HEAD/CMD/P0..P3/CHK frame parser.
// Define UART_RX_PARITY_EN to add an even-parity bit between the data and stop bits.
module uart_recv_control #(
    parameter int         CLK_FREQ     = 200000000,
    parameter int         UART_BPS     = 115200,
    parameter logic [7:0] FRAME_HEAD   = 8'hA5,
    parameter int         TIMEOUT_BITS = 20
) (
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_uart_rxd,
    output logic [7:0]  out_byte_data,
    output logic        out_byte_valid,
    output logic [7:0]  out_cmd,
    output logic [31:0] out_payload,
    output logic        out_frame_valid,
    output logic        out_frame_err,
    output logic        out_uart_recv_busy
);
    localparam int BPS_CNT = CLK_FREQ / UART_BPS;
    localparam int CW = $clog2(BPS_CNT + 1);
    localparam int TW = $clog2(TIMEOUT_BITS * BPS_CNT + 1);
    localparam logic [CW-1:0] MID = CW'(BPS_CNT / 2);
    localparam logic [CW-1:0] LAST = CW'(BPS_CNT - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_BITS * BPS_CNT - 1);

`ifdef UART_RX_PARITY_EN
    typedef enum logic [2:0] {R_IDLE, R_START, R_DATA, R_PARITY, R_STOP} rx_t;
`else
    typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_t;
`endif
    typedef enum logic [1:0] {P_HEAD, P_CMD, P_PAY, P_CHK} ps_t;

    rx_t            r_state, r_next;
    ps_t            p_state, p_next;
    logic           rxd_s1, rxd_s2, rxd_s3;
    logic [CW-1:0]  bit_cnt;
    logic [2:0]     data_idx;
    logic [7:0]     shreg;
    logic           par_ok, stop_at, byte_ok, rx_ferr;
    logic [1:0]     pay_idx;
    logic [7:0]     sum, cmd_r;
    logic [31:0]    pay_r;
    logic [TW-1:0]  tmo;
    logic           frame_ok, frame_bad;

    wire mid  = bit_cnt == MID;
    wire last = bit_cnt == LAST;
    wire fall = rxd_s3 & ~rxd_s2;

`ifdef UART_RX_PARITY_EN
    logic par_err;
    assign par_ok = !par_err;
`else
    assign par_ok = 1'b1;
`endif
    assign stop_at = r_state == R_STOP && mid;
    assign byte_ok = stop_at && rxd_s2 && par_ok;
    assign out_uart_recv_busy = p_state != P_HEAD;

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            r_state <= R_IDLE;
            p_state <= P_HEAD;
        end else begin
            r_state <= r_next;
            p_state <= p_next;
        end
    end

    always_comb begin
        r_next = r_state;
        case (r_state)
            R_IDLE:   r_next = fall ? R_START : R_IDLE;
            R_START:  r_next = (mid && rxd_s2) ? R_IDLE : last ? R_DATA : R_START;
`ifdef UART_RX_PARITY_EN
            R_DATA:   r_next = (last && data_idx == 3'd7) ? R_PARITY : R_DATA;
            R_PARITY: r_next = last ? R_STOP : R_PARITY;
`else
            R_DATA:   r_next = (last && data_idx == 3'd7) ? R_STOP : R_DATA;
`endif
            R_STOP:   r_next = mid ? R_IDLE : R_STOP;
            default:  r_next = R_IDLE;
        endcase
    end

    // Framing and timeout errors only abort a frame already in progress.
    always_comb begin
        p_next = p_state;
        frame_ok = 1'b0;
        frame_bad = 1'b0;
        if (p_state != P_HEAD && (rx_ferr || tmo == TMO_LAST)) begin
            p_next = P_HEAD;
            frame_bad = 1'b1;
        end else if (out_byte_valid) begin
            case (p_state)
                P_HEAD: p_next = (out_byte_data == FRAME_HEAD) ? P_CMD : P_HEAD;
                P_CMD:  p_next = P_PAY;
                P_PAY:  p_next = (pay_idx == 2'd3) ? P_CHK : P_PAY;
                default: begin
                    p_next = P_HEAD;
                    frame_ok = out_byte_data == sum;
                    frame_bad = out_byte_data != sum;
                end
            endcase
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            rxd_s1 <= 1'b1;
            rxd_s2 <= 1'b1;
            rxd_s3 <= 1'b1;
            bit_cnt <= '0;
            data_idx <= '0;
            shreg <= '0;
`ifdef UART_RX_PARITY_EN
            par_err <= 1'b0;
`endif
            out_byte_data <= '0;
            out_byte_valid <= 1'b0;
            rx_ferr <= 1'b0;
            tmo <= '0;
            pay_idx <= '0;
            sum <= '0;
            cmd_r <= '0;
            pay_r <= '0;
            out_cmd <= '0;
            out_payload <= '0;
            out_frame_valid <= 1'b0;
            out_frame_err <= 1'b0;
        end else begin
            rxd_s1 <= in_uart_rxd;
            rxd_s2 <= rxd_s1;
            rxd_s3 <= rxd_s2;
            bit_cnt <= (r_state == R_IDLE || last) ? '0 : bit_cnt + 1'b1;
            if (r_state == R_DATA && mid) shreg <= {rxd_s2, shreg[7:1]};
            if (r_state == R_DATA && last) data_idx <= data_idx + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (r_state == R_PARITY && mid) par_err <= ^{shreg, rxd_s2};
`endif
            out_byte_valid <= byte_ok;
            if (byte_ok) out_byte_data <= shreg;
            rx_ferr <= stop_at && !byte_ok;
            tmo <= (p_state == P_HEAD || out_byte_valid) ? '0 : tmo + 1'b1;
            if (out_byte_valid && p_state == P_CMD) begin
                cmd_r <= out_byte_data;
                sum <= out_byte_data;
                pay_idx <= '0;
            end
            if (out_byte_valid && p_state == P_PAY) begin
                pay_r <= {pay_r[23:0], out_byte_data};
                sum <= sum + out_byte_data;
                pay_idx <= pay_idx + 1'b1;
            end
            out_frame_valid <= frame_ok;
            out_frame_err <= frame_bad;
            if (frame_ok) begin
                out_cmd <= cmd_r;
                out_payload <= pay_r;
            end
        end
    end
endmodule

// File: tb/tb_uart_recv_control.sv
// tb_uart_recv_control: table vectors, corner sequences and random frames checked against a frame-level model.
module tb_uart_recv_control;
    localparam int BIT = 16;
    localparam int TMO = 20 * BIT;

    logic        in_clk = 0, in_rst = 0, in_uart_rxd = 1;
    logic [7:0]  out_byte_data, out_cmd;
    logic        out_byte_valid, out_frame_valid, out_frame_err, out_uart_recv_busy;
    logic [31:0] out_payload;

    uart_recv_control #(.CLK_FREQ(1600000), .UART_BPS(100000)) dut (
        .in_clk(in_clk), .in_rst(in_rst), .in_uart_rxd(in_uart_rxd),
        .out_byte_data(out_byte_data), .out_byte_valid(out_byte_valid),
        .out_cmd(out_cmd), .out_payload(out_payload),
        .out_frame_valid(out_frame_valid), .out_frame_err(out_frame_err),
        .out_uart_recv_busy(out_uart_recv_busy)
    );

    always #5 in_clk = ~in_clk;

    int errors = 0, checks = 0;
    int cyc = 0, n_byte = 0, n_fv = 0, n_fe = 0, bv_cyc = 0, fe_cyc = 0;
    int overlap = 0, stray = 0;
    logic [7:0]  pc = 0;
    logic [31:0] pp = 0;

    always @(negedge in_clk) begin
        cyc++;
        if (out_byte_valid) begin n_byte++; bv_cyc = cyc; end
        if (out_frame_valid) n_fv++;
        if (out_frame_err) begin n_fe++; fe_cyc = cyc; end
        if (out_frame_valid && out_frame_err) overlap++;
        if (!out_frame_valid && in_rst && (out_cmd !== pc || out_payload !== pp)) stray++;
        pc = out_cmd;
        pp = out_payload;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge in_clk);
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        in_uart_rxd = 1'b0;
        tick(BIT);
        for (int i = 0; i < 8; i++) begin
            in_uart_rxd = b[i];
            tick(BIT);
        end
        in_uart_rxd = stop;
        tick(BIT);
        in_uart_rxd = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] pay, input logic [7:0] chk);
        send_byte(8'hA5, 1'b1);
        send_byte(cmd, 1'b1);
        for (int i = 3; i >= 0; i--) send_byte(pay[8*i +: 8], 1'b1);
        send_byte(chk, 1'b1);
        tick(6);
    endtask

    function automatic logic [7:0] model_sum(input logic [7:0] cmd, input logic [31:0] pay);
        int s = int'(cmd);
        for (int i = 0; i < 4; i++) s += int'(pay[8*i +: 8]);
        return 8'(s % 256);
    endfunction

    typedef struct {
        int          njunk;
        logic [7:0]  j0, j1, cmd;
        logic [31:0] pay;
        logic [7:0]  chk;
        int          exp_fv, exp_fe;
        logic [7:0]  exp_cmd;
        logic [31:0] exp_pay;
    } vec_t;

    vec_t tv[3];
    int b0, v0, e0, d;
    logic [7:0]  exp_cmd, rc, rchk;
    logic [31:0] exp_pay, rp;
    logic        bad;
    int          nj;

    initial begin
        tv[0] = '{0, 8'h00, 8'h00, 8'h01, 32'h00000190, 8'h92, 1, 0, 8'h01, 32'h00000190};
        tv[1] = '{0, 8'h00, 8'h00, 8'h01, 32'h00000190, 8'h93, 0, 1, 8'h01, 32'h00000190};
        tv[2] = '{2, 8'h3C, 8'h00, 8'h02, 32'h12345678, 8'h16, 1, 0, 8'h02, 32'h12345678};

        tick(5);
        check("reset byte_valid", out_byte_valid, 0);
        check("reset byte_data", out_byte_data, 0);
        check("reset cmd", out_cmd, 0);
        check("reset payload", out_payload, 0);
        check("reset frame_valid", out_frame_valid, 0);
        check("reset frame_err", out_frame_err, 0);
        check("reset busy", out_uart_recv_busy, 0);
        in_rst = 1;
        tick(10);

        for (int k = 0; k < 3; k++) begin
            b0 = n_byte; v0 = n_fv; e0 = n_fe;
            if (tv[k].njunk > 0) send_byte(tv[k].j0, 1'b1);
            if (tv[k].njunk > 1) send_byte(tv[k].j1, 1'b1);
            send_frame(tv[k].cmd, tv[k].pay, tv[k].chk);
            check($sformatf("vec%0d bytes", k), n_byte - b0, tv[k].njunk + 7);
            check($sformatf("vec%0d frame_valid", k), n_fv - v0, tv[k].exp_fv);
            check($sformatf("vec%0d frame_err", k), n_fe - e0, tv[k].exp_fe);
            check($sformatf("vec%0d cmd", k), out_cmd, tv[k].exp_cmd);
            check($sformatf("vec%0d payload", k), out_payload, tv[k].exp_pay);
            check($sformatf("vec%0d last byte", k), out_byte_data, tv[k].chk);
            check($sformatf("vec%0d busy", k), out_uart_recv_busy, 0);
        end

        // inter-byte timeout
        b0 = n_byte; v0 = n_fv; e0 = n_fe;
        send_byte(8'hA5, 1'b1);
        send_byte(8'h05, 1'b1);
        tick(4);
        check("tmo busy during", out_uart_recv_busy, 1);
        tick(340);
        d = fe_cyc - bv_cyc;
        check("tmo err count", n_fe - e0, 1);
        check("tmo no valid", n_fv - v0, 0);
        check("tmo delay", (d >= TMO - 1 && d <= TMO + 2) ? TMO : d, TMO);
        check("tmo busy after", out_uart_recv_busy, 0);
        v0 = n_fv;
        send_frame(8'h03, 32'hCAFE0001, model_sum(8'h03, 32'hCAFE0001));
        check("tmo next frame", n_fv - v0, 1);
        check("tmo next cmd", out_cmd, 8'h03);
        check("tmo next payload", out_payload, 32'hCAFE0001);

        // start-bit glitch, then bad stop bit inside a frame
        b0 = n_byte; e0 = n_fe;
        in_uart_rxd = 1'b0;
        tick(4);
        in_uart_rxd = 1'b1;
        tick(40);
        check("glitch no byte", n_byte - b0, 0);
        check("glitch no err", n_fe - e0, 0);
        send_byte(8'hA5, 1'b1);
        send_byte(8'h55, 1'b0);
        tick(20);
        check("framing bytes", n_byte - b0, 1);
        check("framing err", n_fe - e0, 1);
        check("framing busy", out_uart_recv_busy, 0);
        check("framing cmd held", out_cmd, 8'h03);

        // reset in the middle of a payload byte
        send_byte(8'hA5, 1'b1);
        send_byte(8'h07, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        in_uart_rxd = 1'b0;
        tick(BIT);
        in_uart_rxd = 1'b1;
        tick(2 * BIT);
        in_uart_rxd = 1'b0;
        tick(BIT / 2);
        b0 = n_byte; v0 = n_fv; e0 = n_fe;
        in_rst = 0;
        in_uart_rxd = 1'b1;
        tick(5);
        check("rst cmd", out_cmd, 0);
        check("rst payload", out_payload, 0);
        check("rst busy", out_uart_recv_busy, 0);
        in_rst = 1;
        tick(40);
        check("rst no bytes", n_byte - b0, 0);
        check("rst no valid", n_fv - v0, 0);
        check("rst no err", n_fe - e0, 0);
        send_frame(8'h09, 32'hDEADBEEF, 8'h41);
        check("rst frame valid", n_fv - v0, 1);
        check("rst frame cmd", out_cmd, 8'h09);
        check("rst frame payload", out_payload, 32'hDEADBEEF);

        // random frames against the frame-level model
        exp_cmd = out_cmd;
        exp_pay = out_payload;
        for (int k = 0; k < 8; k++) begin
            nj = $urandom_range(0, 2);
            rc = 8'($urandom);
            rp = $urandom;
            bad = $urandom_range(0, 2) == 0;
            rchk = model_sum(rc, rp) ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
            b0 = n_byte; v0 = n_fv; e0 = n_fe;
            for (int j = 0; j < nj; j++) begin
                logic [7:0] jb;
                jb = 8'($urandom);
                send_byte(jb == 8'hA5 ? 8'h5A : jb, 1'b1);
            end
            send_frame(rc, rp, rchk);
            if (!bad) begin
                exp_cmd = rc;
                exp_pay = rp;
            end
            check($sformatf("rnd%0d bytes", k), n_byte - b0, nj + 7);
            check($sformatf("rnd%0d frame_valid", k), n_fv - v0, bad ? 0 : 1);
            check($sformatf("rnd%0d frame_err", k), n_fe - e0, bad ? 1 : 0);
            check($sformatf("rnd%0d cmd", k), out_cmd, exp_cmd);
            check($sformatf("rnd%0d payload", k), out_payload, exp_pay);
        end

        check("valid/err overlap", overlap, 0);
        check("cmd/payload changed without valid", stray, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
